// File: rtl/conv_pkg.sv
// Shared definitions for the 3-row convolution column feeder: widths, the idle
// counter sentinel, the fetch FSM states and the packed column layout.
package conv_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned CNT_W = 7;

  localparam logic [CNT_W-1:0] CNT_SENTINEL = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_EMIT
  } state_e;

  // First member lands in the MSBs, so row0 (window top row) sits at [7:0].
  typedef struct packed {
    logic [PIX_W-1:0] row2;
    logic [PIX_W-1:0] row1;
    logic [PIX_W-1:0] row0;
  } col_t;

endpackage

// File: rtl/conv_col_feeder.sv
// Streams 3-pixel columns of a row-major image out of a 1-cycle-latency pixel RAM,
// one column every 4 cycles, tagged with the window row/column counters.
module conv_col_feeder
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIX_W-1:0]     mem_rdata,
  output logic [3*PIX_W-1:0]   pix,
  output logic [CNT_W-1:0]     count_i,
  output logic [CNT_W-1:0]     count_j,
  output logic                 col_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);
  localparam logic [CNT_W-1:0]  LAST_J    = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  LAST_I    = CNT_W'(IMG_H - 3);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [CNT_W-1:0]    j_q, j_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   col_addr;
  logic                rd_en_q, rd_en_d;
  logic [PIX_W-1:0]    row0_q, row1_q;
  col_t                pix_q, emit_col;
  logic [CNT_W-1:0]    ci_q, cj_q;
  logic                col_valid_q, busy_q, done_q;
  logic                last_col;

  assign last_col = (j_q == LAST_J) && (i_q == LAST_I);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    base_d  = base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD0;
          i_d     = '0;
          j_d     = '0;
          base_d  = '0;
        end
      end
      ST_RD0:  state_d = ST_RD1;
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_EMIT;
      ST_EMIT: begin
        if (last_col) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD0;
          if (j_q == LAST_J) begin
            j_d    = '0;
            i_d    = i_q + CNT_W'(1);
            base_d = base_q + ROW_STEP;
          end else begin
            j_d = j_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address is registered against the next state so the strobe lines up with RD0..RD2.
  always_comb begin
    col_addr = base_d + ADDR_W'(j_d);
    addr_d   = addr_q;
    rd_en_d  = 1'b0;
    unique case (state_d)
      ST_RD0: begin addr_d = col_addr;             rd_en_d = 1'b1; end
      ST_RD1: begin addr_d = col_addr + ROW_STEP;  rd_en_d = 1'b1; end
      ST_RD2: begin addr_d = col_addr + ROW_STEP2; rd_en_d = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    emit_col.row2 = mem_rdata;
    emit_col.row1 = row1_q;
    emit_col.row0 = row0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      row0_q      <= '0;
      row1_q      <= '0;
      pix_q       <= '0;
      ci_q        <= CNT_SENTINEL;
      cj_q        <= CNT_SENTINEL;
      col_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      col_valid_q <= (state_d == ST_EMIT);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_q == ST_EMIT) && (state_d == ST_IDLE);
      if (state_q == ST_IDLE && state_d == ST_RD0) begin
        ci_q <= CNT_SENTINEL;
        cj_q <= CNT_SENTINEL;
      end
      if (state_d == ST_EMIT) begin
        ci_q <= i_q;
        cj_q <= j_q;
      end
      if (state_q == ST_RD1) row0_q <= mem_rdata;
      if (state_q == ST_RD2) row1_q <= mem_rdata;
      if (state_q == ST_EMIT) pix_q <= emit_col;
    end
  end

  // Row 2 arrives during EMIT, so it is passed straight through while the column is shown.
  assign pix       = (state_q == ST_EMIT) ? emit_col : pix_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign count_i   = ci_q;
  assign count_j   = cj_q;
  assign col_valid = col_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_col_feeder.sv
// Bench for conv_col_feeder: a 4x4 and a 28x28 instance, each with a 1-cycle RAM,
// checked every cycle against a cycle-offset model plus directed literal checks.
module tb_conv_col_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rstA, startA, rdA, cvA, busyA, doneA;
  logic [3:0]  addrA;
  logic [7:0]  rdataA;
  logic [23:0] pixA;
  logic [6:0]  ciA, cjA;

  logic        rstB, startB, rdB, cvB, busyB, doneB;
  logic [9:0]  addrB;
  logic [7:0]  rdataB;
  logic [23:0] pixB;
  logic [6:0]  ciB, cjB;

  conv_col_feeder #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) dutA (
    .clk(clk), .rst(rstA), .start(startA), .mem_rd_en(rdA), .mem_addr(addrA),
    .mem_rdata(rdataA), .pix(pixA), .count_i(ciA), .count_j(cjA),
    .col_valid(cvA), .busy(busyA), .done(doneA));

  conv_col_feeder #(.IMG_W(28), .IMG_H(28), .ADDR_W(10)) dutB (
    .clk(clk), .rst(rstB), .start(startB), .mem_rd_en(rdB), .mem_addr(addrB),
    .mem_rdata(rdataB), .pix(pixB), .count_i(ciB), .count_j(cjB),
    .col_valid(cvB), .busy(busyB), .done(doneB));

  logic [7:0] ram [2][1024];
  always @(posedge clk) begin
    if (rdA) rdataA <= ram[0][addrA];
    if (rdB) rdataB <= ram[1][addrB];
  end

  int W [2] = '{4, 28};
  int H [2] = '{4, 28};

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model state: pass start edge and values held between columns
  bit          active [2];
  int          kst [2];
  logic [23:0] hpix [2];
  logic [6:0]  hci [2], hcj [2];
  logic [9:0]  haddr [2];

  // captured DUT events for directed checks
  int          ncap [2];
  int          ndone [2];
  int          done_last [2];
  logic [23:0] cap_pix [2][1024];
  int          cap_ci [2][1024], cap_cj [2][1024], cap_cyc [2][1024];

  task automatic model_reset(input int d);
    active[d] = 1'b0;
    hpix[d]   = '0;
    hci[d]    = 7'h7F;
    hcj[d]    = 7'h7F;
    haddr[d]  = '0;
  endtask

  task automatic model_check(input int d, input logic rd, input logic [9:0] addr,
                             input logic [23:0] p, input logic [6:0] ci, input logic [6:0] cj,
                             input logic cv, input logic bz, input logic dn,
                             input logic rst_in, input logic start_in);
    logic [23:0] e_pix;
    logic [6:0]  e_ci, e_cj;
    logic [9:0]  e_addr;
    logic        e_rd, e_cv, e_bz, e_dn;
    logic [46:0] act, exp;
    int t, n, ph, row, col, ncol;
    ncol   = (H[d] - 2) * W[d];
    e_pix  = hpix[d];
    e_ci   = hci[d];
    e_cj   = hcj[d];
    e_addr = haddr[d];
    e_rd = 1'b0; e_cv = 1'b0; e_bz = 1'b0; e_dn = 1'b0;
    if (active[d]) begin
      t = cyc - kst[d] + 1;
      if (t <= 4 * ncol) begin
        e_bz = 1'b1;
        n    = (t - 1) / 4;
        ph   = (t - 1) % 4;
        row  = n / W[d];
        col  = n % W[d];
        if (ph < 3) begin
          e_rd   = 1'b1;
          e_addr = 10'((row + ph) * W[d] + col);
          if (n == 0) begin e_ci = 7'h7F; e_cj = 7'h7F; end
        end else begin
          e_cv  = 1'b1;
          e_ci  = 7'(row);
          e_cj  = 7'(col);
          e_pix = {ram[d][(row + 2) * W[d] + col], ram[d][(row + 1) * W[d] + col],
                   ram[d][row * W[d] + col]};
        end
      end else begin
        e_dn      = 1'b1;
        active[d] = 1'b0;
      end
    end
    hpix[d] = e_pix; hci[d] = e_ci; hcj[d] = e_cj; haddr[d] = e_addr;

    act = {rd, addr, p, ci, cj, cv, bz, dn};
    exp = {e_rd, e_addr, e_pix, e_ci, e_cj, e_cv, e_bz, e_dn};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model%0d cyc=%0d got rd=%b addr=%0d pix=%h ci=%0d cj=%0d cv=%b busy=%b done=%b want rd=%b addr=%0d pix=%h ci=%0d cj=%0d cv=%b busy=%b done=%b",
               d, cyc, rd, addr, p, ci, cj, cv, bz, dn,
               e_rd, e_addr, e_pix, e_ci, e_cj, e_cv, e_bz, e_dn);
    end

    if (cv === 1'b1) begin
      if (ncap[d] < 1024) begin
        cap_pix[d][ncap[d]] = p;
        cap_ci[d][ncap[d]]  = int'(ci);
        cap_cj[d][ncap[d]]  = int'(cj);
        cap_cyc[d][ncap[d]] = cyc;
      end
      ncap[d]++;
    end
    if (dn === 1'b1) begin
      ndone[d]++;
      done_last[d] = cyc;
    end

    if (rst_in) model_reset(d);
    else if (!active[d] && start_in) begin
      active[d] = 1'b1;
      kst[d]    = cyc + 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      model_check(0, rdA, {6'b0, addrA}, pixA, ciA, cjA, cvA, busyA, doneA, rstA, startA);
      model_check(1, rdB, addrB, pixB, ciB, cjB, cvB, busyB, doneB, rstB, startB);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int d, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (ndone[d] < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(ndone[d] >= target), 32'd1);
  endtask

  int k, b, dc1, nd;

  initial begin
    rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      ram[0][a] = 8'(a);
      ram[1][a] = 8'($urandom);
    end
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      ncap[d] = 0; ndone[d] = 0; done_last[d] = 0; kst[d] = 0;
    end
    tick();
    startA = 1'b1;  // start coincident with reset must be ignored
    tick();
    startA = 1'b0;
    rstA = 1'b0; rstB = 1'b0;
    chk_en = 1'b1;

    chk("rst_pix",  32'(pixA), 32'h0);
    chk("rst_ci",   32'(ciA), 32'h7F);
    chk("rst_cj",   32'(cjA), 32'h7F);
    chk("rst_ctl",  32'({rdA, cvA, busyA, doneA}), 32'h0);
    chk("rst_addr", 32'(addrA), 32'h0);
    chk("rst_B",    32'({rdB, cvB, busyB, doneB, addrB, ciB, cjB}), 32'h3FFF);

    // basic pass on 4x4 with RAM[a]=a, plus the max-size pass running in parallel
    b = ncap[0];
    k = cyc + 1;
    startA = 1'b1; startB = 1'b1;
    tick();
    startA = 1'b0; startB = 1'b0;
    wait_done(0, 1, 60, "basic_timeout");
    chk("basic_ncols",  32'(ncap[0] - b), 32'd8);
    chk("basic_first_t", 32'(cap_cyc[0][b]), 32'(k + 3));
    chk("basic_last_t",  32'(cap_cyc[0][b + 7]), 32'(k + 31));
    for (int n = 1; n < 8; n++)
      chk("basic_period", 32'(cap_cyc[0][b + n] - cap_cyc[0][b + n - 1]), 32'd4);
    chk("first_pix",  32'(cap_pix[0][b]), 32'h080400);
    chk("first_cnt",  32'({cap_ci[0][b][6:0], cap_cj[0][b][6:0]}), 32'h0000);
    chk("wrap3_pix",  32'(cap_pix[0][b + 3]), 32'h0B0703);
    chk("wrap3_cnt",  32'({cap_ci[0][b + 3][6:0], cap_cj[0][b + 3][6:0]}), 32'h0003);
    chk("wrap4_pix",  32'(cap_pix[0][b + 4]), 32'h0C0804);
    chk("wrap4_cnt",  32'({cap_ci[0][b + 4][6:0], cap_cj[0][b + 4][6:0]}), 32'h0080);
    chk("last_pix",   32'(cap_pix[0][b + 7]), 32'h0F0B07);
    chk("last_cnt",   32'({cap_ci[0][b + 7][6:0], cap_cj[0][b + 7][6:0]}), 32'h0083);
    chk("done_time",  32'(done_last[0]), 32'(k + 32));
    repeat (3) tick();
    chk("hold_pix", 32'(pixA), 32'h0F0B07);
    chk("hold_cnt", 32'({ciA, cjA}), 32'h0083);

    // back-to-back with start held high
    b  = ncap[0];
    nd = ndone[0];
    k  = cyc + 1;
    startA = 1'b1;
    wait_done(0, nd + 1, 60, "b2b_timeout1");
    dc1 = done_last[0];
    chk("b2b_done1",  32'(dc1), 32'(k + 32));
    chk("b2b_rd0_cnt", 32'({ciA, cjA}), 32'h3FFF);
    chk("b2b_rd0_rd",  32'({rdA, busyA, addrA}), 32'h30);
    startA = 1'b0;
    wait_done(0, nd + 2, 60, "b2b_timeout2");
    chk("b2b_ncols",   32'(ncap[0] - b), 32'd16);
    chk("b2b_restart", 32'(cap_cyc[0][b + 8]), 32'(dc1 + 4));
    chk("b2b_pix",     32'(cap_pix[0][b + 8]), 32'h080400);
    chk("b2b_cnt",     32'({cap_ci[0][b + 8][6:0], cap_cj[0][b + 8][6:0]}), 32'h0000);

    // reset during RD1 of the third column
    nd = ndone[0];
    k  = cyc + 1;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    while (cyc < k + 9) tick();
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    chk("abort_busy", 32'({busyA, doneA, rdA, cvA}), 32'h0);
    chk("abort_cnt",  32'({ciA, cjA}), 32'h3FFF);
    chk("abort_pix",  32'(pixA), 32'h0);
    repeat (10) tick();
    chk("abort_nodone", 32'(ndone[0]), 32'(nd));
    b = ncap[0];
    startA = 1'b1;
    tick();
    startA = 1'b0;
    wait_done(0, nd + 1, 60, "restart_timeout");
    chk("restart_pix", 32'(cap_pix[0][b]), 32'h080400);
    chk("restart_cnt", 32'({cap_ci[0][b][6:0], cap_cj[0][b][6:0]}), 32'h0000);

    // randomized start/reset traffic on fresh RAM contents
    for (int a = 0; a < 16; a++) ram[0][a] = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      startA = ($urandom_range(0, 5) == 0);
      rstA   = ($urandom_range(0, 149) == 0);
      tick();
    end
    startA = 1'b0;
    rstA   = 1'b0;

    // max-size pass
    wait_done(1, 1, 4000, "max_timeout");
    chk("max_ncols", 32'(ncap[1]), 32'd728);
    chk("max_first", 32'({cap_ci[1][0][6:0], cap_cj[1][0][6:0]}), 32'h0000);
    chk("max_last_cnt", 32'({cap_ci[1][727][6:0], cap_cj[1][727][6:0]}), 32'((25 << 7) | 27));
    chk("max_last_pix", 32'(cap_pix[1][727]), 32'({ram[1][783], ram[1][755], ram[1][727]}));
    chk("max_last_addr", 32'(addrB), 32'd783);
    chk("max_idle", 32'({busyB, rdB}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_col_feeder.md
# conv_col_feeder

Column streamer that drives the 3-row convolution stage. It walks a row-major image held in a synchronous single-port pixel RAM and reads three vertically adjacent pixels per column. It presents them as one packed 24-bit column together with the window row/column counters. The convolution stage detects a new column from a change in `count_i`/`count_j`, so every emitted column carries a counter pair that differs from the previous one.

## Interface
- `IMG_W`, 28, image width in pixels (3..126)
- `IMG_H`, 28, image height in pixels (3..126)
- `ADDR_W`, 10, pixel RAM address width; must satisfy IMG_W*IMG_H ≤ 2^ADDR_W
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one full image pass; sampled only in IDLE
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_W  RAM read address
- `mem_rdata`  in  8  RAM read data, valid exactly 1 cycle after `mem_rd_en`
- `pix`  out  24  {row i+2, row i+1, row i} pixels of column j; [7:0] is the top row
- `count_i`  out  7  window top-row index
- `count_j`  out  7  column index
- `col_valid`  out  1  1-cycle pulse when `pix`/counters update to a real column
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  1-cycle pulse after the last column

## Operation
- FSM states: IDLE, RD0, RD1, RD2, EMIT.
  - IDLE + `start` → RD0.
  - RD0 → RD1 → RD2 → EMIT.
  - EMIT → RD0 if more columns remain, else IDLE with `done`=1 for that cycle.
- Reads per column use `base` = i*IMG_W, held in a register that is advanced by +IMG_W per row. No multiplier.
  - RD0 issues `base+j`.
  - RD1 issues `base+IMG_W+j` and captures row 0.
  - RD2 issues `base+2*IMG_W+j` and captures row 1.
  - EMIT captures row 2 directly into `pix[23:16]`.
- In EMIT, `pix` and the counters update together and `col_valid`=1.
- Scan order: j runs 0..IMG_W-1 within each i, and i runs 0..IMG_H-3. That is (IMG_H-2)*IMG_W columns per pass.
- Idle sentinel: counters reset to 7'h7F and are forced to 7'h7F in the RD0 cycle following `start`.
  - This guarantees the first column (0,0) registers as a change downstream.
  - The sentinel transition itself makes the downstream stage compute one garbage column. This is accepted because its output is invalid for the first 3 columns anyway.
- After `done`, `pix`, `count_i` and `count_j` hold their last values until the next `start`.
- `start` during `busy` is ignored. `start` coincident with `rst` is ignored.
- `mem_rd_en`=1 only in RD0/RD1/RD2. `mem_addr` holds its last value otherwise.

## Timing
- Reset values:
  - state IDLE
  - `pix`=0
  - `count_i`=`count_j`=7'h7F
  - `mem_rd_en`=0, `mem_addr`=0
  - `col_valid`=`busy`=`done`=0
- `start` sampled high at edge k. RD0 occupies cycle k+1, and the first `col_valid` is in cycle k+4.
- Column period is exactly 4 cycles. The n-th column (n from 0) has `col_valid` at k+4+4n.
- `done` occurs 1 cycle after the last EMIT, so at k+4*(IMG_H-2)*IMG_W+1. `busy` drops in the same cycle as `done`.
- `rst` mid-pass aborts immediately to reset values. No `done` is generated, and the next pass requires a fresh `start`.
- Row wrap: the column after (i, IMG_W-1) is (i+1, 0). `count_i` and `count_j` change in the same cycle.

## Structure
- Shared package `conv_pkg`:
  - pixel width 8
  - counter width 7
  - the sentinel 7'h7F
  - FSM state enum (IDLE, RD0, RD1, RD2, EMIT)
  - the packed-column layout (top row at the LSB)
- No sub-module required. Address generation (`base`, j, i counters) stays inline.
- The bench uses a 1-cycle-latency RAM model.

## Test plan
- Reset: assert `rst` 2 cycles.
  - All outputs take their reset values; `count_i`=`count_j`=7'h7F.
- Basic pass: IMG_W=4, IMG_H=4, RAM[a]=a, `start` at edge k.
  - 8 `col_valid` pulses at k+4, k+8 … k+32.
  - First column: `pix`=24'h080400, counters (0,0).
  - Last column: `pix`=24'h0F0B07, counters (1,3).
  - `done` at k+33.
- Row wrap: same image. The 4th and 5th columns must be (0,3) with `pix`=24'h0B0703, then (1,0) with `pix`=24'h0C0804.
- Back-to-back: `start` held high throughout.
  - The second pass begins the cycle after `done`.
  - Counters go 7'h7F in RD0, then (0,0) at the next EMIT.
  - Pulses inside a pass are ignored.
- Reset mid-operation: `rst` during the 3rd column's RD1.
  - Next cycle is IDLE, `busy`=0, no `done`, counters 7'h7F.
  - A new `start` restarts from (0,0).
- Max size: IMG_W=IMG_H=28, `ADDR_W`=10.
  - 728 columns.
  - Last `mem_addr` issued is 783.
  - Final counters are (25,27).
